fetch_queue: RTL and testbench

- IF stage of the pipelined RV32 core: owns the fetch PC and issues in-order requests to instruction memory.
- Buffers returned words in a small queue and presents them to the IF/ID pipeline register, which is an enable/clear flop.
- Honours the hazard unit's stall, and taken-branch redirects from EX, by discarding wrong-path responses still in flight.

---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 156 +++++++++++++++
 tb/tb_fetch_queue.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch queue (master) and imem (slave).
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_queue.sv
// IF stage: owns the fetch PC, issues in-order imem requests, buffers words for IF/ID.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module fetch_queue_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic          rsp_valid,
    input logic [CW-1:0] count,
    input logic [CW-1:0] outstanding
);
    push_not_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count != CW'(DEPTH)));
    rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (outstanding != {CW{1'b0}}));
endmodule

module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_queue_if.master   imem,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);
    localparam logic [XLEN-1:0] STEP4   = XLEN'(32'd4);
    localparam logic [XLEN-1:0] ALIGN_M = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] fetch_pc_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   discard_r;
    logic [PW-1:0]   q_rd_r;
    logic [PW-1:0]   q_wr_r;
    logic [PW-1:0]   f_rd_r;
    logic [PW-1:0]   f_wr_r;
    logic [31:0]     q_instr_r [DEPTH];
    logic [XLEN-1:0] q_pc_r    [DEPTH];
    logic [XLEN-1:0] q_pc4_r   [DEPTH];
    logic [XLEN-1:0] f_pc_r    [DEPTH];

    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic            accept_s;
    logic [CW:0]     used_s;

    assign instr_valid    = (count_r != {CW{1'b0}});
    assign instr          = q_instr_r[q_rd_r];
    assign pc             = q_pc_r[q_rd_r];
    assign pc_plus4       = q_pc4_r[q_rd_r];
    assign imem.imem_addr = fetch_pc_r;

    // Handshake decode; credits count queued words plus requests still in flight.
    always_comb begin
        pop_s               = instr_valid && !stall && !redirect_valid;
        used_s              = {1'b0, count_r} + {1'b0, outstanding_r} - (CW+1)'(pop_s);
        imem.imem_req_valid = rst_n && !redirect_valid && (used_s < DEPTH_C);
        accept_s            = imem.imem_req_valid && imem.imem_req_ready;
        push_s              = imem.imem_rsp_valid && (discard_r == {CW{1'b0}}) && !redirect_valid;
        drop_s              = imem.imem_rsp_valid && !push_s;
    end

    // Fetch PC, occupancy counters and queue pointers; redirect flushes and arms discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
            q_rd_r        <= {PW{1'b0}};
            q_wr_r        <= {PW{1'b0}};
        end else begin
            outstanding_r <= outstanding_r + CW'(accept_s) - CW'(imem.imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc_r <= redirect_pc & ALIGN_M;
                count_r    <= {CW{1'b0}};
                q_wr_r     <= q_rd_r;
                discard_r  <= outstanding_r - CW'(imem.imem_rsp_valid);
            end else begin
                if (accept_s) fetch_pc_r <= fetch_pc_r + STEP4;
                count_r <= count_r + CW'(push_s) - CW'(pop_s);
                if (pop_s)  q_rd_r <= q_rd_r + PTR_ONE;
                if (push_s) q_wr_r <= q_wr_r + PTR_ONE;
                if (drop_s) discard_r <= discard_r - CW'(1);
            end
        end
    end

    // Storage: in-flight request PCs and the instruction queue entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rd_r <= {PW{1'b0}};
            f_wr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_r[i] <= 32'd0;
                q_pc_r[i]    <= {XLEN{1'b0}};
                q_pc4_r[i]   <= {XLEN{1'b0}};
                f_pc_r[i]    <= {XLEN{1'b0}};
            end
        end else begin
            if (accept_s) begin
                f_pc_r[f_wr_r] <= fetch_pc_r;
                f_wr_r         <= f_wr_r + PTR_ONE;
            end
            if (imem.imem_rsp_valid) f_rd_r <= f_rd_r + PTR_ONE;
            if (push_s) begin
                q_instr_r[q_wr_r] <= imem.imem_rsp_data;
                q_pc_r[q_wr_r]    <= f_pc_r[f_rd_r];
                q_pc4_r[q_wr_r]   <= f_pc_r[f_rd_r] + STEP4;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Retired-fetch and wrong-path-drop counters, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_dropped <= 32'd0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop_s);
            perf_dropped <= perf_dropped + 32'(drop_s)
                          + (redirect_valid ? 32'(count_r) : 32'd0);
        end
    end
`endif

    fetch_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push_s),
        .rsp_valid   (imem.imem_rsp_valid),
        .count       (count_r),
        .outstanding (outstanding_r)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed + randomized bench for fetch_queue against a request-tagging queue model.
module tb_fetch_queue;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0080;

    typedef struct { logic [31:0] addr; bit killed; int cyc; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    fetch_queue_if #(.XLEN(XLEN)) imem_bus ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] arch_pc;
    int          cyc;
    int          checks;
    int          errors;
    int          accepts;
    int          rsp_mode;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_bus.imem_req_ready = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = 32'd0;
        #1;
        chk("rst_req_valid", imem_bus.imem_req_valid, 32'd0);
        chk("rst_instr_valid", instr_valid, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc_plus4", pc_plus4, 32'd0);
        pend.delete();
        mq.delete();
        m_fetch_pc = RESET_PC;
        arch_pc    = RESET_PC;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req_valid", imem_bus.imem_req_valid, 32'd1);
        chk("rel_addr", imem_bus.imem_addr, RESET_PC);
        chk("rel_pc_zero", pc, 32'd0);
    endtask

    // One clock: drive inputs after the edge, check and advance the model at the negedge.
    task automatic step(input bit st, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit   pop_e;
        bit   rsp;
        bit   exp_req;
        int   used;
        req_t r;
        ent_t e;
        @(posedge clk);
        #1;
        cyc++;
        stall = st;
        redirect_valid = rv;
        redirect_pc = rpc;
        imem_bus.imem_req_ready = rdy;
        rsp = (pend.size() > 0) && (pend[0].cyc < cyc) &&
              ((rsp_mode == 0) || ((rsp_mode == 1) && ($urandom_range(1, 0) == 1)));
        imem_bus.imem_rsp_valid = rsp;
        imem_bus.imem_rsp_data  = rsp ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
        @(negedge clk);
        pop_e   = (mq.size() != 0) && !st && !rv;
        used    = mq.size() + pend.size() - int'(pop_e);
        exp_req = !rv && (used < DEPTH);
        chk("req_valid", imem_bus.imem_req_valid, exp_req);
        if (exp_req) chk("imem_addr", imem_bus.imem_addr, m_fetch_pc);
        chk("instr_valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("head_pc", pc, mq[0].pc);
            chk("head_instr", instr, mq[0].data);
            chk("head_pc_plus4", pc_plus4, mq[0].pc + 32'd4);
        end
        if (pop_e) begin
            chk("arch_stream_pc", pc, arch_pc);
            arch_pc = arch_pc + 32'd4;
            void'(mq.pop_front());
        end
        if (rsp) begin
            r = pend.pop_front();
            if (!r.killed && !rv) begin
                e.pc = r.addr;
                e.data = mem_word(r.addr);
                mq.push_back(e);
            end
        end
        if (exp_req && rdy) begin
            r.addr = m_fetch_pc;
            r.killed = 1'b0;
            r.cyc = cyc;
            pend.push_back(r);
            m_fetch_pc = m_fetch_pc + 32'd4;
            accepts++;
        end
        if (rv) begin
            mq.delete();
            foreach (pend[i]) pend[i].killed = 1'b1;
            m_fetch_pc = {rpc[31:2], 2'b00};
            arch_pc = m_fetch_pc;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc0;
        logic [31:0] a0;
        checks = 0; errors = 0; cyc = 0; accepts = 0; rsp_mode = 0;

        // Streaming with single-cycle latency.
        do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b1); chk("stream_c1_iv", instr_valid, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1); chk("stream_c2_iv", instr_valid, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1); chk("stream_pc0", pc, 32'h80);
        step(1'b0, 1'b0, 32'd0, 1'b1); chk("stream_pc1", pc, 32'h84);
        step(1'b0, 1'b0, 32'd0, 1'b1); chk("stream_pc2", pc, 32'h88);
        chk("stream_pc2_plus4", pc_plus4, 32'h8C);

        // Stall holding 0x80 at the head.
        do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        acc0 = accepts;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            chk("stall_hold_pc", pc, 32'h80);
            chk("stall_hold_instr", instr, mem_word(32'h80));
        end
        chk("stall_accept_budget", (accepts - acc0 + 1) <= DEPTH, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1); chk("stall_rel_pc0", pc, 32'h80);
        step(1'b0, 1'b0, 32'd0, 1'b1); chk("stall_rel_pc1", pc, 32'h84);

        // Redirect with two requests in flight.
        do_reset();
        rsp_mode = 2;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        rsp_mode = 0;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("redir_next_addr", imem_bus.imem_addr, 32'h100);
        chk("redir_iv_low", instr_valid, 32'd0);
        for (int i = 0; i < 8 && !instr_valid; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("redir_first_iv", instr_valid, 32'd1);
        chk("redir_first_pc", pc, 32'h100);

        // Backpressure: address held, one accept on release.
        step(1'b0, 1'b0, 32'd0, 1'b0);
        a0 = imem_bus.imem_addr;
        chk("bp_valid", imem_bus.imem_req_valid, 32'd1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            chk("bp_addr_held", imem_bus.imem_addr, a0);
        end
        acc0 = accepts;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("bp_dut_addr", imem_bus.imem_addr, a0);
        chk("bp_one_accept", accepts - acc0, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("bp_next_addr", imem_bus.imem_addr, a0 + 32'd4);

        // Address wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Reset with two queued words and one request outstanding.
        do_reset();
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        chk("mid_iv_before", instr_valid, 32'd1);
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Randomized traffic.
        do_reset();
        rsp_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0,
                 32'h0000_1000 + ($urandom_range(255, 0) << 2) + $urandom_range(3, 0),
                 $urandom_range(9, 0) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
